// File: rtl/crack_scheduler.sv
// crack_scheduler: launches NUM_CORES ARC4 crack engines over an interleaved
// key space, round-robin shares the ciphertext memory between them, picks the
// winning key and aborts the engines that are still searching.
module crack_scheduler #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned CORE_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  output logic                      rdy,
  output logic [23:0]               key,
  output logic                      key_valid,
  output logic [7:0]                ct_addr,
  input  logic [7:0]                ct_rddata,
  output logic [NUM_CORES-1:0]      core_en,
  output logic [24*NUM_CORES-1:0]   core_key_base,
  output logic [NUM_CORES-1:0]      core_abort,
  input  logic [NUM_CORES-1:0]      core_rdy,
  input  logic [NUM_CORES-1:0]      core_key_valid,
  input  logic [24*NUM_CORES-1:0]   core_key,
  input  logic [NUM_CORES-1:0]      core_ct_req,
  input  logic [8*NUM_CORES-1:0]    core_ct_addr,
  output logic [NUM_CORES-1:0]      core_ct_gnt,
  output logic [NUM_CORES-1:0]      core_ct_rvalid,
  output logic [7:0]                core_ct_rddata
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LAUNCH     = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_ABORT      = 3'd4;
  localparam logic [2:0] S_DRAIN      = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [23:0]          key_q, key_d;
  logic                 key_valid_q, key_valid_d;
  logic [NUM_CORES-1:0] win;
  logic [23:0]          best_key;
  logic                 best_found;
  logic [CORE_W-1:0]    ptr_q, ptr_d;
  logic [NUM_CORES-1:0] gnt;
  logic [CORE_W-1:0]    gnt_idx;
  logic                 gnt_any;
  logic [7:0]           ct_addr_q;
  logic [NUM_CORES-1:0] rvalid_q;

  // Finished cores that report a readable key.
  assign win = core_rdy & core_key_valid;

  // Lowest key among winners; strict compare keeps the lowest index on a tie.
  always_comb begin
    best_key   = '1;
    best_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (win[i] && (!best_found || (core_key[24*i +: 24] < best_key))) begin
        best_key   = core_key[24*i +: 24];
        best_found = 1'b1;
      end
    end
  end

  // Run sequencing: launch, wait for all cores busy, pick winner, abort, drain.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d     = S_LAUNCH;
          key_d       = '0;
          key_valid_d = 1'b0;
        end
      end
      S_LAUNCH:     state_d = S_WAIT_START;
      S_WAIT_START: if (core_rdy == '0) state_d = S_RUN;
      S_RUN: begin
        if (win != '0) begin
          key_d       = best_key;
          key_valid_d = 1'b1;
          state_d     = S_ABORT;
        end else if (core_rdy == '1) begin
          key_d       = '0;
          key_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_ABORT:  state_d = (core_rdy == '1) ? S_IDLE : S_DRAIN;
      S_DRAIN:  if (core_rdy == '1) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencer state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Round-robin search: first requester at or above the pointer, modulo NUM_CORES.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (!gnt_any && core_ct_req[i] && (i == ((32'(ptr_q) + k) % NUM_CORES))) begin
          gnt[i]  = 1'b1;
          gnt_idx = CORE_W'(i);
          gnt_any = 1'b1;
        end
      end
    end
  end

  // Memory address follows the granted core, otherwise holds the last one.
  always_comb begin
    ct_addr = ct_addr_q;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (gnt[i]) ct_addr = core_ct_addr[8*i +: 8];
    end
  end

  // Pointer moves just past the granted core.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == CORE_W'(NUM_CORES - 1)) ? '0 : gnt_idx + CORE_W'(1);
    end
  end

  // Arbiter state; rvalid lines up with the synchronous memory read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      ct_addr_q <= '0;
      rvalid_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      ct_addr_q <= ct_addr;
      rvalid_q  <= gnt;
    end
  end

  // Core i starts at key i and strides by NUM_CORES.
  always_comb begin
    core_key_base = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_key_base[24*i +: 24] = 24'(i);
    end
  end

  assign rdy            = (state_q == S_IDLE);
  assign key            = key_q;
  assign key_valid      = key_valid_q;
  assign core_en        = (state_q == S_LAUNCH) ? '1 : '0;
  assign core_abort     = (state_q == S_ABORT) ? ~core_rdy : '0;
  assign core_ct_gnt    = gnt;
  assign core_ct_rvalid = rvalid_q;
  assign core_ct_rddata = ct_rddata;

endmodule

// File: tb/tb_crack_scheduler.sv
// tb_crack_scheduler: behavioural crack-engine models and a ciphertext memory
// around crack_scheduler, with a per-cycle arbiter model and run-level checks.
module tb_crack_scheduler;
  localparam int NC = 2;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              rdy;
  logic [23:0]       key;
  logic              key_valid;
  logic [7:0]        ct_addr;
  logic [7:0]        ct_rddata = '0;
  logic [NC-1:0]     core_en;
  logic [24*NC-1:0]  core_key_base;
  logic [NC-1:0]     core_abort;
  logic [NC-1:0]     drv_rdy = '1;
  logic [NC-1:0]     drv_kv = '0;
  logic [24*NC-1:0]  drv_key = '0;
  logic [NC-1:0]     drv_req = '0;
  logic [8*NC-1:0]   drv_addr = '0;
  logic [NC-1:0]     core_ct_gnt;
  logic [NC-1:0]     core_ct_rvalid;
  logic [7:0]        core_ct_rddata;

  crack_scheduler #(.NUM_CORES(NC), .CORE_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata), .core_en(core_en),
    .core_key_base(core_key_base), .core_abort(core_abort), .core_rdy(drv_rdy),
    .core_key_valid(drv_kv), .core_key(drv_key), .core_ct_req(drv_req),
    .core_ct_addr(drv_addr), .core_ct_gnt(core_ct_gnt), .core_ct_rvalid(core_ct_rvalid),
    .core_ct_rddata(core_ct_rddata)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  // scenario for the engine models: finish delay, result valid, result key
  int          sc_d [NC];
  logic        sc_v [NC];
  logic [23:0] sc_k [NC];

  int   cst [NC];   // 0 idle, 1 searching, 2 aborting
  int   ccnt [NC];
  int   n_abort [NC];
  int   n_en_pulses = 0;
  logic arb_fixed = 1'b0;
  logic [7:0] fix_addr [NC];

  logic              s_rdy, s_kv;
  logic [23:0]       s_key;
  logic [NC-1:0]     s_core_en = '0, s_abort = '0, s_gnt = '0, s_rvalid = '0;
  logic [7:0]        s_ct_addr, s_rddata;

  logic [1:0] lit_g [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
  logic [7:0] lit_a [4] = '{8'h05, 8'h09, 8'h05, 8'h09};
  logic [7:0] lit_d [2] = '{8'h5F, 8'h53};

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  // Synchronous-read ciphertext memory.
  initial forever begin
    @(posedge clk);
    ct_rddata = mem[ct_addr];
  end

  // Engine models: react to last cycle's start/abort/grant, then drive this cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        cst[i]  = 0;
        ccnt[i] = 0;
      end
      drv_rdy = '1; drv_kv = '0; drv_key = '0; drv_req = '0; drv_addr = '0;
    end else begin
      if (s_core_en != '0) n_en_pulses++;
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (s_abort[i] && cst[i] != 1) begin
          errors++;
          $display("FAIL abort_legal core%0d: abort while engine state %0d, required 1", i, cst[i]);
        end
        case (cst[i])
          0: if (s_core_en[i]) begin
               cst[i] = 1; ccnt[i] = sc_d[i];
               drv_rdy[i] = 1'b0; drv_kv[i] = 1'b0; drv_key[24*i +: 24] = '0;
             end
          1: if (s_abort[i]) begin
               n_abort[i]++;
               cst[i] = 2;
               ccnt[i] = int'($urandom_range(1, 4));
             end else begin
               ccnt[i]--;
               if (ccnt[i] == 0) begin
                 cst[i] = 0; drv_rdy[i] = 1'b1;
                 drv_kv[i] = sc_v[i]; drv_key[24*i +: 24] = sc_k[i];
               end
             end
          default: begin
            ccnt[i]--;
            if (ccnt[i] == 0) begin
              cst[i] = 0; drv_rdy[i] = 1'b1;
            end
          end
        endcase
        if (arb_fixed) begin
          drv_req[i] = 1'b1;
          drv_addr[8*i +: 8] = fix_addr[i];
        end else if (cst[i] == 0) begin
          drv_req[i] = 1'b0;
        end else if (drv_req[i] && s_gnt[i]) begin
          if ($urandom_range(0, 1) == 0) drv_req[i] = 1'b0;
          else drv_addr[8*i +: 8] = 8'($urandom);
        end else if (!drv_req[i] && $urandom_range(0, 1) == 1) begin
          drv_req[i] = 1'b1;
          drv_addr[8*i +: 8] = 8'($urandom);
        end
      end
    end
    #1;
    s_rdy = rdy; s_kv = key_valid; s_key = key; s_core_en = core_en;
    s_abort = core_abort; s_gnt = core_ct_gnt; s_rvalid = core_ct_rvalid;
    s_ct_addr = ct_addr; s_rddata = core_ct_rddata;
  end

  // Per-cycle arbiter model: rotating-priority grant, address hold, delayed rvalid.
  initial begin
    int ptr_m, pg, g;
    logic [7:0] paddr, last_addr, ea;
    logic [NC-1:0] eg, erv;
    ptr_m = 0; pg = -1; paddr = '0; last_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        ptr_m = 0; pg = -1; last_addr = '0;
      end else begin
        g = -1;
        for (int k = 0; k < NC; k++) begin
          if (g < 0 && drv_req[(ptr_m + k) % NC]) g = (ptr_m + k) % NC;
        end
        eg = '0; ea = last_addr;
        if (g >= 0) begin
          eg[g] = 1'b1;
          ea = drv_addr[8*g +: 8];
        end
        erv = '0;
        if (pg >= 0) erv[pg] = 1'b1;
        chk("arb_gnt", 32'(core_ct_gnt), 32'(eg));
        chk("arb_ct_addr", 32'(ct_addr), 32'(ea));
        chk("arb_rvalid", 32'(core_ct_rvalid), 32'(erv));
        if (pg >= 0) chk("arb_rddata", 32'(core_ct_rddata), 32'(mem[paddr]));
        if (rdy) chk("rdy_implies_cores_idle", 32'(drv_rdy), 32'({NC{1'b1}}));
        if (g >= 0) begin
          ptr_m = (g + 1) % NC;
          last_addr = ea;
        end
        pg = g; paddr = ea;
      end
    end
  end

  // One full run: start, stray en mid-run, wait for idle, compare the outcome
  // with the result derived from the engines' finish times.
  task automatic run_case(input string nm);
    int T, n;
    logic any;
    logic [23:0] ek;
    int ab_exp [NC];
    T = 1 << 30;
    for (int i = 0; i < NC; i++) if (sc_v[i] && sc_d[i] < T) T = sc_d[i];
    // an engine finishing exactly in the abort cycle is pushed one cycle later
    for (int i = 0; i < NC; i++) if (T < (1 << 30) && sc_d[i] == T + 1) sc_d[i] = T + 2;
    any = 1'b0; ek = '0;
    for (int i = 0; i < NC; i++) begin
      if (sc_v[i] && sc_d[i] == T && (!any || sc_k[i] < ek)) begin
        ek = sc_k[i]; any = 1'b1;
      end
    end
    for (int i = 0; i < NC; i++) begin
      ab_exp[i] = (any && sc_d[i] > T + 1) ? 1 : 0;
      n_abort[i] = 0;
    end
    n = 0;
    while (!s_rdy && n < 200) begin cyc(); n++; end
    chk({nm, "_idle_before"}, 32'(s_rdy), 32'd1);
    n_en_pulses = 0;
    en = 1'b1;
    cyc();
    en = 1'b0;
    chk({nm, "_core_en_launch"}, 32'(s_core_en), 32'({NC{1'b1}}));
    chk({nm, "_rdy_low"}, 32'(s_rdy), 32'd0);
    cyc();
    chk({nm, "_core_en_single"}, 32'(s_core_en), 32'd0);
    en = 1'b1;
    cyc();
    en = 1'b0;
    n = 0;
    while (!s_rdy && n < 400) begin cyc(); n++; end
    chk({nm, "_done"}, 32'(s_rdy), 32'd1);
    chk({nm, "_key"}, 32'(s_key), 32'(ek));
    chk({nm, "_key_valid"}, 32'(s_kv), 32'(any));
    for (int i = 0; i < NC; i++) chk({nm, "_abort_count"}, 32'(n_abort[i]), 32'(ab_exp[i]));
    repeat (3) cyc();
    chk({nm, "_launch_count"}, 32'(n_en_pulses), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    for (int i = 0; i < NC; i++) begin
      sc_d[i] = 1; sc_v[i] = 1'b0; sc_k[i] = '0; fix_addr[i] = '0; n_abort[i] = 0;
    end

    // reset state
    repeat (3) cyc();
    chk("rst_rdy", 32'(s_rdy), 32'd1);
    chk("rst_key_valid", 32'(s_kv), 32'd0);
    chk("rst_key", 32'(s_key), 32'd0);
    chk("rst_core_en", 32'(s_core_en), 32'd0);
    chk("rst_core_abort", 32'(s_abort), 32'd0);
    chk("rst_gnt", 32'(s_gnt), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_ct_addr", 32'(s_ct_addr), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_rdy", 32'(s_rdy), 32'd1);
    chk("post_rst_core_en", 32'(s_core_en), 32'd0);
    for (int i = 0; i < NC; i++) chk("key_base", 32'(core_key_base[24*i +: 24]), 32'(i));

    // both engines hold requests to 05 / 09: grants alternate from core 0
    fix_addr[0] = 8'h05; fix_addr[1] = 8'h09;
    arb_fixed = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("dir_gnt", 32'(s_gnt), 32'(lit_g[n]));
      if (n < 4) chk("dir_ct_addr", 32'(s_ct_addr), 32'(lit_a[n]));
      if (n > 0) begin
        chk("dir_rvalid", 32'(s_rvalid), 32'(lit_g[n-1]));
        chk("dir_rddata", 32'(s_rddata), 32'(lit_d[(n-1) % 2]));
      end
      if (n == 3) arb_fixed = 1'b0;
    end

    // core 1 wins with key 3 while core 0 still searching
    sc_d = '{50, 5}; sc_v = '{1'b0, 1'b1}; sc_k = '{24'h000123, 24'h000003};
    run_case("win_abort");
    chk("win_abort_key_lit", 32'(s_key), 32'h000003);
    chk("win_abort_abort0_lit", 32'(n_abort[0]), 32'd1);

    // simultaneous finish, lower key wins
    sc_d = '{7, 7}; sc_v = '{1'b1, 1'b1}; sc_k = '{24'h000010, 24'h00000F};
    run_case("simul");
    chk("simul_key_lit", 32'(s_key), 32'h00000F);

    // nothing found
    sc_d = '{4, 9}; sc_v = '{1'b0, 1'b0}; sc_k = '{24'h000077, 24'h000088};
    run_case("nokey");
    chk("nokey_key_lit", 32'(s_key), 32'h000000);
    chk("nokey_valid_lit", 32'(s_kv), 32'd0);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NC; i++) begin
        sc_d[i] = int'($urandom_range(1, 40));
        sc_v[i] = ($urandom_range(0, 1) == 1);
        sc_k[i] = 24'($urandom);
      end
      if (r % 4 == 0) begin
        sc_d[1] = sc_d[0]; sc_v[0] = 1'b1; sc_v[1] = 1'b1;
      end
      if (r % 4 == 1) begin
        sc_d[1] = sc_d[0]; sc_v[0] = 1'b1; sc_v[1] = 1'b1; sc_k[1] = sc_k[0];
      end
      run_case("rand");
    end

    // reset asserted mid-run
    sc_d = '{60, 60}; sc_v = '{1'b1, 1'b1}; sc_k = '{24'h000001, 24'h000002};
    en = 1'b1;
    cyc();
    en = 1'b0;
    repeat (5) cyc();
    chk("midrst_busy", 32'(s_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(rdy), 32'd1);
    chk("midrst_core_en", 32'(core_en), 32'd0);
    chk("midrst_core_abort", 32'(core_abort), 32'd0);
    chk("midrst_key_valid", 32'(key_valid), 32'd0);
    chk("midrst_key", 32'(key), 32'd0);
    cyc();
    chk("midrst_gnt", 32'(s_gnt), 32'd0);
    chk("midrst_ct_addr", 32'(s_ct_addr), 32'd0);
    chk("midrst_rvalid", 32'(s_rvalid), 32'd0);
    rst_n = 1'b1;
    cyc();

    // recovery run after reset
    sc_d = '{3, 8}; sc_v = '{1'b1, 1'b0}; sc_k = '{24'h0ABCDE, 24'h000000};
    run_case("recover");
    chk("recover_key_lit", 32'(s_key), 32'h0ABCDE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crack_scheduler.md
Name: crack_scheduler

Overview:
- Top-level sequencer for the parallel ARC4 key-cracking circuit.
- Launches NUM_CORES crack engines over an interleaved 24-bit key space: core i tests keys i, i+NUM_CORES, i+2·NUM_CORES, …
- Round-robin arbitrates the single shared ciphertext memory between the engines.
- Selects the winning key and aborts the losing engines, presenting the same en/rdy/key/key_valid interface as a single cracker.

Parameters:
- NUM_CORES, 2, number of crack engines; 2..8.
- CORE_W, 3, index width; must satisfy 2**CORE_W >= NUM_CORES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  start request; accepted only while rdy=1.
- rdy  output  1  high when idle and able to accept en.
- key  output  24  winning key; valid when rdy=1 and key_valid=1.
- key_valid  output  1  a readable key was found in the last run.
- ct_addr  output  8  address to the ciphertext memory (synchronous read, 1-cycle latency).
- ct_rddata  input  8  ciphertext read data.
- core_en  output  NUM_CORES  one-cycle start pulse per core.
- core_key_base  output  24*NUM_CORES  first key for core i; slice i = i, constant.
- core_abort  output  NUM_CORES  one-cycle stop pulse; the core returns to rdy within 4 cycles.
- core_rdy  input  NUM_CORES  core idle.
- core_key_valid  input  NUM_CORES  core found a readable key.
- core_key  input  24*NUM_CORES  core result key.
- core_ct_req  input  NUM_CORES  core requests a ct read; held until granted.
- core_ct_addr  input  8*NUM_CORES  requested address.
- core_ct_gnt  output  NUM_CORES  combinational grant, one-hot or zero.
- core_ct_rvalid  output  NUM_CORES  pulses the cycle after that core's grant.
- core_ct_rddata  output  8  ct_rddata broadcast to all cores.

Behaviour:
- Reset (async) values:
  - rdy=1, key=0, key_valid=0.
  - core_en=0, core_abort=0.
  - core_ct_rvalid=0, core_ct_gnt=0, ct_addr=0.
  - RR pointer=0; state IDLE.
- Reset asserted mid-run forces the reset state immediately. Cores are reset by the same rst_n.
- IDLE (rdy=1):
  - en=1 → LAUNCH; clear key_valid and key.
  - en ignored in all other states.
- LAUNCH: core_en asserted to all cores for exactly one cycle, rdy=0 → WAIT_START.
- WAIT_START: wait until all core_rdy=0 → RUN. Cores may take 1 cycle to drop rdy.
- RUN, examined each cycle for cores i with core_rdy[i]=1:
  - Any such core with core_key_valid[i]=1 → capture the lowest core_key among them (the lowest index wins a tie of equal keys); key_valid=1; go to ABORT.
  - Else if all cores are rdy with no valid → key_valid=0, key=0 → IDLE.
  - A core that finishes without a valid key stays finished; the others continue.
- ABORT:
  - Pulse core_abort one cycle for every core with core_rdy=0.
  - Then wait for all core_rdy=1 → IDLE with rdy=1.
  - rdy rises only after every core is idle.
- Arbiter (active in all states):
  - Grant the requester at or after the RR pointer, searching upward modulo NUM_CORES.
  - ct_addr = granted core_ct_addr combinationally. When there is no grant, ct_addr holds its last value.
  - The pointer moves to granted index+1 (wrapping NUM_CORES-1 → 0).
  - core_ct_rvalid[g] is registered: high the cycle after the grant, aligned with ct_rddata.
  - Exactly one grant per cycle; peak throughput 1 read/cycle.
  - A granted core must deassert or change its request after the grant. A request still high in the grant cycle is a new request.
  - Requests from a core being aborted are still served. Its rvalid may arrive after the abort and is harmless.
- Key arithmetic: core_key_base slice i = i zero-extended to 24 bits. Each core advances by NUM_CORES and stops past 24'hFFFFFF; wrap is not permitted.

Test Plan:
- Reset: rst_n=0 then 1 → rdy=1, key_valid=0, core_en=0, core_ct_gnt=0.
- Start: en pulse while rdy=1 → core_en=all ones exactly one cycle, rdy=0 next cycle; a second en mid-run is ignored (no new core_en).
- Arbitration: NUM_CORES=2, both cores hold core_ct_req with addr 8'h05/8'h09 → grants alternate 0,1,0,1; ct_addr alternates 05,09; each rvalid one cycle after its grant with the matching memory data.
- Win plus abort: core 1 reports key 24'h000003 valid while core 0 is running → key=000003, key_valid=1, core_abort[0] pulses once, rdy=1 only after core_rdy[0]=1.
- Simultaneous finish: cores 0 and 1 rdy in the same cycle with valid keys 24'h000010 and 24'h00000F → key=00000F.
- No key: all cores finish with core_key_valid=0 → rdy=1, key_valid=0, key=0; full system on test1.memh gives the key equal to a software exhaustive search, with matching plaintext.
